// File: rtl/lcd_host.sv
// Host-side sequencer for an LCD controller: queues commands, issues them
// one at a time, and captures the written frame. LCD_HOST_CKSUM_EN builds the pixel checksum.
module lcd_host (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  q_cmd,
    input  logic        q_push,
    output logic        q_full,
    output logic [2:0]  cmd,
    output logic        cmd_valid,
    input  logic        busy,
    input  logic        done,
    input  logic        IRB_RW,
    input  logic [5:0]  IRB_A,
    input  logic [7:0]  IRB_D,
    input  logic [5:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        frame_done,
    output logic [13:0] checksum
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_ACK, WAIT_REL, CAPTURE, FIN
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  fifo_q [8];
    logic [2:0]  wr_ptr_q, rd_ptr_q;
    logic [3:0]  cnt_q;
    logic [2:0]  cmd_q;
    logic        frame_done_q;
    logic [7:0]  buf_q [64];
    logic        pop, push_ok, cap_wr;

    assign q_full     = (cnt_q == 4'd8);
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign push_ok    = q_push && (!q_full || pop);
    assign cmd        = cmd_q;
    assign cmd_valid  = (state_q == ISSUE);
    assign frame_done = frame_done_q;
    assign rd_data    = buf_q[rd_addr];

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        cap_wr  = 1'b0;
        case (state_q)
            IDLE:     if (cnt_q != 4'd0 && !busy) state_d = ISSUE;
            ISSUE: begin
                pop     = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: if (busy) state_d = (cmd_q == 3'd0) ? CAPTURE : WAIT_REL;
            WAIT_REL: if (!busy) state_d = IDLE;
            CAPTURE: begin
                cap_wr = !IRB_RW;
                if (done) state_d = FIN;
            end
            FIN:      state_d = FIN;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= 3'd0;
            rd_ptr_q     <= 3'd0;
            cnt_q        <= 4'd0;
            cmd_q        <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 3'd1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 3'd1;
            cnt_q    <= cnt_q + {3'd0, push_ok} - {3'd0, pop};
            // Latch the head on entry to ISSUE so cmd holds it afterwards.
            if (state_q == IDLE && state_d == ISSUE) cmd_q <= fifo_q[rd_ptr_q];
            if (state_q == CAPTURE && done) frame_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) fifo_q[wr_ptr_q] <= q_cmd;
    end

    always_ff @(posedge clk) begin
        if (!reset && cap_wr) buf_q[IRB_A] <= IRB_D;
    end

`ifdef LCD_HOST_CKSUM_EN
    logic [13:0] cksum_q;

    always_ff @(posedge clk) begin
        if (reset)       cksum_q <= 14'd0;
        else if (cap_wr) cksum_q <= cksum_q + {6'd0, IRB_D};
    end

    assign checksum = cksum_q;
`else
    assign checksum = 14'd0;
`endif

endmodule

// File: tb/tb_lcd_host.sv
// Scoreboard bench for lcd_host: pushes expected commands into a queue, a
// monitor checks each issue; a controller model acks commands and writes frames.
module tb_lcd_host;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  q_cmd;
    logic        q_push;
    logic        q_full;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        done;
    logic        IRB_RW;
    logic [5:0]  IRB_A;
    logic [7:0]  IRB_D;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        frame_done;
    logic [13:0] checksum;

    lcd_host dut (
        .clk(clk), .reset(reset), .q_cmd(q_cmd), .q_push(q_push), .q_full(q_full),
        .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
        .IRB_RW(IRB_RW), .IRB_A(IRB_A), .IRB_D(IRB_D), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_done(frame_done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] exp_q [$];
    int         issues = 0;
    logic [7:0] exp_buf [64];
    int         exp_sum = 0;
    int         cap_cnt = 0;
    int         stray_req = 0;
    int         stray_ack = 0;
    bit         hold = 1'b0;
    bit         cap_done_en = 1'b1;
    int         cap_n = 64;
    int         pat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic int exp_ck();
`ifdef LCD_HOST_CKSUM_EN
        return exp_sum;
`else
        return 0;
`endif
    endfunction

    // Monitor: every issue strobe must match the oldest accepted command.
    initial begin
        forever begin
            @(negedge clk);
            if (cmd_valid === 1'b1) begin
                issues++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: got cmd %0d expected no issue", cmd);
                end else begin
                    chk("issue_cmd", cmd, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Controller model: busy for two cycles after each issue; write-out streams a frame.
    initial begin
        bit         wr_cmd;
        logic [7:0] d;
        busy = 1'b0; done = 1'b0; IRB_RW = 1'b1; IRB_A = 6'd0; IRB_D = 8'd0;
        forever begin
            @(negedge clk);
            if (hold) busy = 1'b1;
            else if (stray_req != stray_ack) begin
                IRB_RW = 1'b0; IRB_A = 6'd3; IRB_D = 8'd77;
                @(negedge clk);
                IRB_RW = 1'b1;
                stray_ack++;
            end else if (cmd_valid === 1'b1) begin
                wr_cmd = (cmd == 3'd0);
                busy = 1'b1;
                @(negedge clk);
                @(negedge clk);
                busy = 1'b0;
                if (wr_cmd) begin
                    exp_sum = 0;
                    for (int i = 0; i < cap_n; i++) begin
                        d = (pat == 0) ? 8'(i + 1) : (pat == 1) ? 8'd255 : 8'($urandom_range(0, 255));
                        IRB_RW = 1'b0; IRB_A = 6'(i); IRB_D = d;
                        exp_buf[i] = d;
                        exp_sum += d;
                        @(negedge clk);
                    end
                    IRB_RW = 1'b1;
                    if (cap_done_en) begin
                        done = 1'b1;
                        @(negedge clk);
                        done = 1'b0;
                    end
                    cap_cnt++;
                end
            end else busy = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; the model accepts when not full or when a pop is under way.
    task automatic push(input logic [2:0] c);
        q_cmd = c;
        q_push = 1'b1;
        if (exp_q.size() < 8 || cmd_valid === 1'b1) exp_q.push_back(c);
        cyc(1);
        q_push = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            cyc(1);
            if (exp_q.size() == 0) break;
        end
        if (k == 400) timeout(name);
        cyc(4);
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (done) break;
        end
        if (k == 400) timeout(name);
    endtask

    task automatic reset_dut();
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int n0, c0, k, a;
        reset = 1'b1; q_push = 1'b0; q_cmd = 3'd0; rd_addr = 6'd0;
        cyc(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_q_full", q_full, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_checksum", checksum, 0);

        // Basic ordered issue
        cyc(1);
        n0 = issues;
        push(3'd1); push(3'd4); push(3'd2);
        drain("drain_basic");
        chk("basic_issue_count", issues - n0, 3);

        // Random command stream with random gaps
        n0 = issues;
        c0 = 0;
        for (int i = 0; i < 25; i++) begin
            if (exp_q.size() < 8 || cmd_valid === 1'b1) c0++;
            push(3'($urandom_range(1, 7)));
            cyc($urandom_range(0, 3));
        end
        drain("drain_random");
        chk("random_issue_count", issues - n0, c0);

        // Fill while busy: ninth push dropped
        hold = 1'b1;
        cyc(2);
        n0 = issues;
        for (int i = 0; i < 9; i++) push(3'($urandom_range(1, 7)));
        chk("full_after_9", q_full, 1);
        cyc(5);
        chk("no_issue_while_busy", issues - n0, 0);
        hold = 1'b0;
        drain("drain_full");
        chk("full_issue_count", issues - n0, 8);
        chk("empty_after_drain", q_full, 0);

        // Push into full queue during the ISSUE pop
        hold = 1'b1;
        cyc(2);
        n0 = issues;
        for (int i = 0; i < 8; i++) push(3'($urandom_range(1, 7)));
        chk("full_before_pop", q_full, 1);
        hold = 1'b0;
        for (k = 0; k < 20; k++) begin
            if (cmd_valid === 1'b1) break;
            cyc(1);
        end
        if (k == 20) timeout("wait_issue");
        push(3'd5);
        chk("full_after_push_pop", q_full, 1);
        drain("drain_pushpop");
        chk("pushpop_issue_count", issues - n0, 9);

        // Frame capture with D = A + 1
        pat = 0; cap_n = 64; cap_done_en = 1'b1;
        push(3'd0);
        wait_done("wait_done_inc");
        chk("frame_done_before", frame_done, 0);
        @(negedge clk);
        #1;
        chk("frame_done_after", frame_done, 1);
        rd_addr = 6'd5;
        #1;
        chk("rd_data_5", rd_data, 6);
        chk("rd_data_5_model", rd_data, exp_buf[5]);
        chk("checksum_inc", checksum, exp_ck());
        n0 = issues;
        cyc(1);
        push(3'd3);
        cyc(10);
        chk("no_issue_in_fin", issues - n0, 0);
        chk("frame_done_sticky", frame_done, 1);

        // Saturated frame
        reset_dut();
        @(negedge clk);
        chk("rst2_frame_done", frame_done, 0);
        chk("rst2_checksum", checksum, 0);
        pat = 1;
        cyc(1);
        push(3'd0);
        wait_done("wait_done_max");
        cyc(2);
        chk("checksum_max", checksum, exp_ck());
        chk("frame_done_max", frame_done, 1);

        // Reset mid-capture
        reset_dut();
        pat = 2; cap_n = 10; cap_done_en = 1'b0;
        c0 = cap_cnt;
        push(3'd0);
        for (k = 0; k < 200; k++) begin
            if (cap_cnt != c0) break;
            cyc(1);
        end
        if (k == 200) timeout("wait_partial");
        reset_dut();
        @(negedge clk);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_checksum", checksum, 0);
        chk("abort_q_full", q_full, 0);
        stray_req++;
        for (k = 0; k < 20; k++) begin
            if (stray_ack == stray_req) break;
            cyc(1);
        end
        if (k == 20) timeout("wait_stray");
        cyc(1);
        chk("stray_checksum", checksum, 0);
        for (int i = 0; i < 10; i++) begin
            rd_addr = 6'(i);
            #1;
            chk("buf_kept", rd_data, exp_buf[i]);
        end
        n0 = issues;
        push(3'd6);
        drain("drain_after_abort");
        chk("idle_after_abort", issues - n0, 1);

        // Random frame
        reset_dut();
        pat = 2; cap_n = 64; cap_done_en = 1'b1;
        push(3'd0);
        wait_done("wait_done_rand");
        cyc(2);
        chk("checksum_rand", checksum, exp_ck());
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, 63);
            rd_addr = 6'(a);
            #1;
            chk("rd_data_rand", rd_data, exp_buf[a]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
